dual_tx_n: RTL and testbench
============================

# dual_tx_n

Four-phase, return-to-null transmitter for dual-rail word bundles. It takes N single-rail words of BITS bits from a clocked valid/ready source and drives them as dual-rail rails (`val0`/`val1`). It waits for per-word completion acknowledges from the receiving side (the per-word `done` of the completion detector), then drives the null spacer and waits for the acknowledges to fall. It is the clocked-to-async launch point that feeds completion-detected dual-rail datapaths.

## Interface
Parameters:
- `N`, 2: number of words per bundle.
- `BITS`, `` `size ``: bits per word.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: source offers a bundle.
- `in_ready`, out, 1: block accepts a bundle this cycle.
- `in_data`, in, [N-1:0][BITS-1:0]: single-rail bundle.
- `in_mask`, in, [N-1:0]: words to transmit; unmasked words stay null and their acks are ignored.
- `val0`, out, Dual [N-1:0][BITS-1:0]: rail 0. High encodes bit 0.
- `val1`, out, Dual [N-1:0][BITS-1:0]: rail 1. High encodes bit 1.
- `ack`, in, [N-1:0]: per-word completion from the receiver; high = word complete, low = word null.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- Encoding per bit, for masked words:
  - Data bit d drives `val1=d`, `val0=~d`.
  - Null drives `val0=val1=0`.
  - `val0=val1=1` is never driven.
- Rails and state are registered. Rails change only on state entry, never mid-state.
- `mask_q`, `data_q`: captured on accept.
- FSM states:
  - **IDLE**: rails null. `in_ready = (ack == 0)`. On `in_valid & in_ready`, capture `in_data`/`in_mask` and go to DATA.
  - **DATA**: masked words carry encoded `data_q`; unmasked words stay null. When every masked word's ack is 1 (`(ack & mask_q) == mask_q`), go to NULL.
  - **NULL**: all rails null. When `(ack & mask_q) == 0`, go to IDLE.
- Reset values: state IDLE, all `val0`/`val1` 0, `data_q`/`mask_q` 0, `busy` 0. `in_ready` is 0 while `rst` is high.
- Boundary conditions:
  - **Mask all zero:** the completion condition is trivially true. DATA lasts 1 cycle, NULL lasts 1 cycle, rails stay null throughout.
  - **Stale high ack in IDLE:** `in_ready` is held low until all ack bits are 0. The block never launches onto an incomplete spacer.
  - **Ack on an unmasked word:** ignored in DATA and NULL. It still blocks `in_ready` in IDLE.
  - **Early ack fall in DATA:** ack bits dropping before all masked acks are high is legal. The block keeps waiting; no error is raised.
  - **Reset mid-operation:** rails go null asynchronously and the state returns to IDLE. The captured bundle is discarded.
  - **`in_valid` outside IDLE:** ignored; no capture.

## Timing
- Accept at edge t: DATA rails are valid from t+1 and `busy` goes high at t+1.
- Full ack high sampled at edge k: rails are null from k+1.
- Full ack low sampled at edge m: IDLE from m+1. `in_ready` rises at m+1 if all acks are low.
- Minimum handshake: 3 cycles per bundle with an immediately responding receiver. Back-to-back accept is possible at the first IDLE cycle.
- Ack is treated as asynchronous to `clk`. Rails are glitch-free because they come straight from flops.

## Configuration
- `DUAL_TX_ACK_SYNC_EN`
  - **Defined:** `ack` passes through a 2-flop synchronizer per bit before any use, including the IDLE `in_ready` gate. This adds 2 cycles to each ack-dependent transition, so the minimum handshake is 7 cycles.
  - **Undefined:** `ack` is used directly (receiver must be in the `clk` domain). Minimum handshake is 3 cycles.

## Structure
- The shared package (`defs.svh`) holds:
  - the `Dual` typedef, `` `size ``, `` `true ``;
  - the new state enum `dual_tx_state_e` {IDLE, DATA, NULL}.
- Sub-module `ack_sync #(.W(N))`: 2-flop synchronizer with asynchronous active-high reset to 0. It is instantiated only under `DUAL_TX_ACK_SYNC_EN`.
- Encode logic stays inline in the top module.

## Test plan
- **Single bundle:** N=2, BITS=4, `in_data={4'hA,4'h3}`, mask=2'b11, ack loops back from a `done_n` model.
  - Cycle 1: `val1[1]=4'hA`, `val0[1]=4'h5`, `val1[0]=4'h3`, `val0[0]=4'hC`.
  - Rails return to null; `in_ready` is high again 3 cycles after accept (7 with sync).
- **Partial mask:** mask=2'b01, ack[1] held 0.
  - Word 1 rails stay 0 throughout.
  - The handshake completes on ack[0] alone.
- **Zero mask:** mask=2'b00.
  - Rails stay null.
  - `busy` is high for exactly 2 cycles; no dependence on ack.
- **Stale ack:** ack=2'b10 in IDLE with `in_valid=1`.
  - `in_ready=0` and no capture.
  - Drop the ack: accepted the following edge.
- **Slow receiver:** ack[0] rises 5 cycles after ack[1].
  - Rails hold data until both acks are high.
  - No null is driven early; no `val0=val1=1` at any cycle.
- **Reset mid-DATA:** assert `rst` asynchronously while in DATA.
  - Rails are 0 before the next clock edge.
  - After release: IDLE, `in_ready=1` with ack low, prior data is not re-sent.

Source files
------------

// File: rtl/dual_tx_n_pkg.sv
// Shared definitions for the dual-rail transmitter: the Dual rail type,
// the default word width, a boolean helper and the transmitter state enum.
`ifndef DUAL_TX_DEFS_SVH
`define DUAL_TX_DEFS_SVH
`define DUAL_TX_SIZE 8
`define DUAL_TX_TRUE 1'b1
`endif

package dual_tx_n_pkg;

    // One rail bit of a dual-rail signal; rails are plain wires.
    typedef logic Dual;

    // Four-phase handshake position: spacer, data wave, null wave.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        NULL = 2'd2
    } dual_tx_state_e;

endpackage

// File: rtl/dual_tx_n_ack_sync.sv
// ack_sync: per-bit two-flop synchronizer for the receiver's completion acks.
// Only present when DUAL_TX_ACK_SYNC_EN is defined, because only that build
// of dual_tx_n instantiates it.
`ifdef DUAL_TX_ACK_SYNC_EN
module ack_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture of the asynchronous ack bits, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule
`endif

// File: rtl/dual_tx_n.sv
// dual_tx_n: four-phase return-to-null launcher for dual-rail word bundles.
// A bundle accepted from the valid/ready source is driven as dual-rail data,
// held until every transmitted word reports complete, then replaced by the
// null spacer until the acks fall again.
// Optional build macro: DUAL_TX_ACK_SYNC_EN adds a 2-flop ack synchronizer
// in front of every use of ack (default: ack used directly, clk domain).
`ifndef DUAL_TX_DEFS_SVH
`define DUAL_TX_DEFS_SVH
`define DUAL_TX_SIZE 8
`define DUAL_TX_TRUE 1'b1
`endif

module dual_tx_n
    import dual_tx_n_pkg::*;
#(
    parameter int N    = 2,
    parameter int BITS = `DUAL_TX_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0][BITS-1:0]   in_data,
    input  logic [N-1:0]             in_mask,
    output logic [N-1:0][BITS-1:0]   val0,
    output logic [N-1:0][BITS-1:0]   val1,
    input  logic [N-1:0]             ack,
    output logic                     busy
);

    dual_tx_state_e             state_r;
    logic [N-1:0][BITS-1:0]     data_q;
    logic [N-1:0]               mask_q;
    logic [N-1:0]               ack_s;
    logic [N-1:0]               ack_masked_s;
    logic                       all_done_s;
    logic                       all_null_s;
    logic                       ready_s;

    // Rail encoding: rail 1 carries the bit, rail 0 its complement; words
    // outside the mask stay null on both rails so 1/1 can never appear.
    function automatic logic [N-1:0][BITS-1:0] encode_rails(
        input logic [N-1:0][BITS-1:0] d,
        input logic [N-1:0]           m,
        input logic                   rail
    );
        Dual [N-1:0][BITS-1:0] r;
        for (int w = 0; w < N; w++) begin
            if (m[w]) begin
                r[w] = rail ? d[w] : ~d[w];
            end else begin
                r[w] = {BITS{1'b0}};
            end
        end
        return r;
    endfunction

`ifdef DUAL_TX_ACK_SYNC_EN
    ack_sync #(.W(N)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack),
        .q   (ack_s)
    );
`else
    assign ack_s = ack;
`endif

    // Acks on words that were not transmitted never gate DATA or NULL exit.
    assign ack_masked_s = ack_s & mask_q;
    assign all_done_s   = (ack_masked_s == mask_q);
    assign all_null_s   = (ack_masked_s == {N{1'b0}});

    // Launch only onto a fully returned spacer; any high ack blocks, masked
    // or not, and nothing is accepted while reset is applied.
    assign ready_s  = (state_r == IDLE) && (ack_s == {N{1'b0}}) && !rst;
    assign in_ready = ready_s;

    // Handshake sequencer; rails and busy are loaded only on state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            data_q  <= '0;
            mask_q  <= {N{1'b0}};
            val0    <= '0;
            val1    <= '0;
            busy    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && ready_s) begin
                        data_q  <= in_data;
                        mask_q  <= in_mask;
                        val1    <= encode_rails(in_data, in_mask, 1'b1);
                        val0    <= encode_rails(in_data, in_mask, 1'b0);
                        busy    <= `DUAL_TX_TRUE;
                        state_r <= DATA;
                    end else begin
                        val0    <= '0;
                        val1    <= '0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                DATA: begin
                    if (all_done_s) begin
                        val0    <= '0;
                        val1    <= '0;
                        state_r <= NULL;
                    end else begin
                        // Same value as loaded on entry: rails hold steady.
                        val1    <= encode_rails(data_q, mask_q, 1'b1);
                        val0    <= encode_rails(data_q, mask_q, 1'b0);
                        state_r <= DATA;
                    end
                end
                NULL: begin
                    if (all_null_s) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= NULL;
                    end
                end
                default: begin
                    val0    <= '0;
                    val1    <= '0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_tx_n.sv
// Self-checking bench for dual_tx_n (N=2, BITS=4, default build).
module tb_dual_tx_n;

    localparam int N    = 2;
    localparam int BITS = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0][BITS-1:0] in_data;
    logic [N-1:0]           in_mask;
    logic [N-1:0][BITS-1:0] val0;
    logic [N-1:0][BITS-1:0] val1;
    logic [N-1:0]           ack;
    logic                   busy;

    logic                   loop_en;
    logic [N-1:0]           ack_man;
    logic [N-1:0]           done_s;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: handshake phase (0 spacer, 1 data wave, 2 null wave)
    int                     ph;
    logic [N-1:0]           m_mask;
    logic [N-1:0][BITS-1:0] m_data;

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        logic [7:0] v1;
        logic [7:0] v0;
    } vec_t;

    vec_t vecs [6];

    dual_tx_n #(.N(N), .BITS(BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mask  (in_mask),
        .val0     (val0),
        .val1     (val1),
        .ack      (ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Completion detector of the receiver: a word is done when every bit
    // shows exactly one rail high.
    always_comb begin
        done_s = '0;
        for (int w = 0; w < N; w++) begin
            done_s[w] = &(val0[w] | val1[w]);
        end
    end

    assign ack = loop_en ? done_s : ack_man;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0][BITS-1:0] m_rail(input logic one);
        logic [N-1:0][BITS-1:0] r;
        r = '0;
        if (ph == 1) begin
            for (int w = 0; w < N; w++) begin
                if (m_mask[w]) r[w] = one ? m_data[w] : ~m_data[w];
            end
        end
        return r;
    endfunction

    function automatic logic m_ready();
        return (ph == 0) && (ack == 2'b00) && !rst;
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic cyc();
        int nph;
        logic cap;
        logic [N-1:0] am;
        logic [N-1:0] nm;
        logic [N-1:0][BITS-1:0] nd;
        @(negedge clk);
        chk("val1", val1, m_rail(1'b1));
        chk("val0", val0, m_rail(1'b0));
        chk("busy", busy, (ph != 0));
        chk("in_ready", in_ready, m_ready());
        chk("no_both_rails", val0 & val1, 64'd0);
        nph = ph;
        cap = 1'b0;
        nm  = in_mask;
        nd  = in_data;
        am  = ack & m_mask;
        if (rst) nph = 0;
        else if (ph == 0 && in_valid && m_ready()) begin nph = 1; cap = 1'b1; end
        else if (ph == 1 && am == m_mask) nph = 2;
        else if (ph == 2 && am == 2'b00) nph = 0;
        @(posedge clk);
        ph = nph;
        if (cap) begin m_mask = nm; m_data = nd; end
        #1;
    endtask

    initial begin
        vecs[0] = '{d: 8'hA3, m: 2'b11, v1: 8'hA3, v0: 8'h5C};
        vecs[1] = '{d: 8'h3C, m: 2'b01, v1: 8'h0C, v0: 8'h03};
        vecs[2] = '{d: 8'h5F, m: 2'b10, v1: 8'h50, v0: 8'hA0};
        vecs[3] = '{d: 8'hFF, m: 2'b00, v1: 8'h00, v0: 8'h00};
        vecs[4] = '{d: 8'h00, m: 2'b11, v1: 8'h00, v0: 8'hFF};
        vecs[5] = '{d: 8'h96, m: 2'b11, v1: 8'h96, v0: 8'h69};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = 2'b00;
        loop_en = 1'b0; ack_man = 2'b00;
        ph = 0; m_mask = 2'b00; m_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_val0", val0, 64'd0);
        chk("rst_val1", val1, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_in_ready", in_ready, 64'd0);
        rst = 1'b0;
        cyc();

        // Table: one bundle each with an immediately responding receiver
        loop_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = vecs[i].d; in_mask = vecs[i].m; in_valid = 1'b1;
            cyc();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_val1", i), val1, vecs[i].v1);
            chk($sformatf("tbl%0d_val0", i), val0, vecs[i].v0);
            chk($sformatf("tbl%0d_busy_data", i), busy, 64'd1);
            cyc();
            chk($sformatf("tbl%0d_null_rails", i), val0 | val1, 64'd0);
            chk($sformatf("tbl%0d_busy_null", i), busy, 64'd1);
            chk($sformatf("tbl%0d_ready_null", i), in_ready, 64'd0);
            cyc();
            chk($sformatf("tbl%0d_busy_idle", i), busy, 64'd0);
            chk($sformatf("tbl%0d_ready_idle", i), in_ready, 64'd1);
        end

        // Partial mask with an ack on the untransmitted word
        loop_en = 1'b0; ack_man = 2'b00;
        in_data = 8'h7E; in_mask = 2'b01; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0; ack_man = 2'b10;
        repeat (3) cyc();
        chk("pm_hold_val1", val1, 64'h0E);
        chk("pm_hold_val0", val0, 64'h01);
        ack_man = 2'b11;
        cyc();
        chk("pm_null", val0 | val1, 64'd0);
        ack_man = 2'b10;
        cyc();
        chk("pm_idle_busy", busy, 64'd0);
        chk("pm_unmasked_blocks", in_ready, 64'd0);
        ack_man = 2'b00;
        cyc();
        chk("pm_ready_again", in_ready, 64'd1);

        // Stale ack in IDLE: no capture until it drops
        ack_man = 2'b10; in_data = 8'h2D; in_mask = 2'b11; in_valid = 1'b1;
        repeat (2) cyc();
        chk("stale_no_capture", busy, 64'd0);
        ack_man = 2'b00;
        cyc();
        in_valid = 1'b0;
        chk("stale_accept_busy", busy, 64'd1);
        chk("stale_accept_val1", val1, 64'h2D);
        loop_en = 1'b1;
        repeat (2) cyc();
        loop_en = 1'b0;

        // Slow receiver: ack[0] rises 5 cycles after ack[1]
        in_data = 8'hC5; in_mask = 2'b11; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0; ack_man = 2'b10;
        repeat (5) cyc();
        chk("slow_hold_val1", val1, 64'hC5);
        chk("slow_hold_val0", val0, 64'h3A);
        ack_man = 2'b01;
        cyc();
        chk("slow_early_fall", val1, 64'hC5);
        ack_man = 2'b11;
        cyc();
        chk("slow_null", val0 | val1, 64'd0);
        ack_man = 2'b00;
        cyc();

        // Reset mid-DATA: rails must clear before the next edge
        in_data = 8'h69; in_mask = 2'b11; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        #2 rst = 1'b1; ph = 0;
        #1;
        chk("rstmid_val0", val0, 64'd0);
        chk("rstmid_val1", val1, 64'd0);
        chk("rstmid_busy", busy, 64'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("rstmid_ready", in_ready, 64'd1);
        repeat (2) cyc();

        // Randomized traffic against a lagging receiver
        for (int c = 0; c < 600; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            in_mask  = 2'($urandom);
            for (int w = 0; w < N; w++) begin
                if (ack_man[w] != done_s[w] && $urandom_range(0, 2) == 0)
                    ack_man[w] = done_s[w];
            end
            cyc();
        end

        // Drain to IDLE within a bounded number of cycles
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            ack_man = done_s;
            cyc();
        end
        chk("drain_idle", busy, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
